// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants and types for the instruction aligner
package ifu_pkg;

    localparam int          PC_LEN     = 64;
    localparam logic [63:0] RST_PC     = 64'h0000_0000_8000_0000;

    // Opcode bits [1:0] that mark a full 32-bit instruction; anything else is RVC.
    localparam logic [1:0]  RVC_OPC_32 = 2'b11;

    // Halfword select for the FIFO head word.
    localparam logic        HW_LO      = 1'b0;   // [15:0]
    localparam logic        HW_HI      = 1'b1;   // [31:16]

    // Which way the next instruction is extracted from the head word.
    typedef enum logic [1:0] {
        ALIGN_LO   = 2'd0,   // start at low halfword
        ALIGN_HI   = 2'd1,   // start at high halfword
        ALIGN_JOIN = 2'd2    // finish a straddling 32-bit instruction
    } align_case_e;

    function automatic logic is_rvc(input logic [15:0] h);
        return h[1:0] != RVC_OPC_32;
    endfunction

endpackage

// File: rtl/ifu_inst_align.sv
// rtl/ifu_inst_align.sv - splits 32-bit fetch words into RVC/32-bit instructions with PCs
module ifu_inst_align #(
    parameter int              PC_LEN = ifu_pkg::PC_LEN,
    parameter logic [PC_LEN-1:0] RST_PC = ifu_pkg::RST_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [PC_LEN-1:0] flush_pc,
    input  logic              fifo_empty,
    input  logic [31:0]       fifo_rdata,
    output logic              fifo_rready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [PC_LEN-1:0] inst_pc,
    output logic              inst_is_rvc
);
    import ifu_pkg::*;

    logic [PC_LEN-1:0] pc_next_q, pc_next_d;
    logic              off_q, off_d;
    logic              half_valid_q, half_valid_d;
    logic [15:0]       half_buf_q, half_buf_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [PC_LEN-1:0] inst_pc_q, inst_pc_d;
    logic              inst_is_rvc_q, inst_is_rvc_d;

    logic              adv;
    logic [15:0]       lo_half;
    logic [15:0]       hi_half;
    align_case_e       acase;
    logic              flush_pc_unused;

    // Redirect targets are halfword aligned, so bit 0 carries no information.
    assign flush_pc_unused = flush_pc[0];

    assign lo_half = fifo_rdata[15:0];
    assign hi_half = fifo_rdata[31:16];

    // The output slot is free (empty or being drained) and a head word is present.
    assign adv = (!inst_valid_q || inst_ready) && !fifo_empty && !flush && !rst;

    // Pick the extraction case from the halfword pointer and straddle buffer.
    always_comb begin
        acase = ALIGN_LO;
        if (half_valid_q) begin
            acase = ALIGN_JOIN;
        end else if (off_q == HW_HI) begin
            acase = ALIGN_HI;
        end
    end

    // Next-state for PC tracking, straddle buffer, output register and FIFO pop.
    always_comb begin
        pc_next_d     = pc_next_q;
        off_d         = off_q;
        half_valid_d  = half_valid_q;
        half_buf_d    = half_buf_q;
        inst_valid_d  = inst_valid_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_is_rvc_d = inst_is_rvc_q;
        fifo_rready   = 1'b0;

        if (flush) begin
            inst_valid_d = 1'b0;
            half_valid_d = 1'b0;
            pc_next_d    = {flush_pc[PC_LEN-1:1], 1'b0};
            off_d        = flush_pc[1];
        end else begin
            // Decode took the entry; a new issue below overrides this with no bubble.
            if (inst_valid_q && inst_ready) begin
                inst_valid_d = 1'b0;
            end
            if (adv) begin
                case (acase)
                    ALIGN_LO: begin
                        inst_valid_d = 1'b1;
                        inst_pc_d    = pc_next_q;
                        if (is_rvc(lo_half)) begin
                            inst_d        = {16'h0, lo_half};
                            inst_is_rvc_d = 1'b1;
                            pc_next_d     = pc_next_q + PC_LEN'(2);
                            off_d         = HW_HI;
                        end else begin
                            inst_d        = fifo_rdata;
                            inst_is_rvc_d = 1'b0;
                            pc_next_d     = pc_next_q + PC_LEN'(4);
                            off_d         = HW_LO;
                            fifo_rready   = 1'b1;
                        end
                    end
                    ALIGN_HI: begin
                        fifo_rready = 1'b1;
                        off_d       = HW_LO;
                        if (is_rvc(hi_half)) begin
                            inst_valid_d  = 1'b1;
                            inst_d        = {16'h0, hi_half};
                            inst_pc_d     = pc_next_q;
                            inst_is_rvc_d = 1'b1;
                            pc_next_d     = pc_next_q + PC_LEN'(2);
                        end else begin
                            // Park the low half; the instruction completes from the next word.
                            half_buf_d   = hi_half;
                            half_valid_d = 1'b1;
                        end
                    end
                    ALIGN_JOIN: begin
                        inst_valid_d  = 1'b1;
                        inst_d        = {lo_half, half_buf_q};
                        inst_pc_d     = pc_next_q;
                        inst_is_rvc_d = 1'b0;
                        pc_next_d     = pc_next_q + PC_LEN'(4);
                        half_valid_d  = 1'b0;
                        off_d         = HW_HI;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_next_q     <= RST_PC;
            off_q         <= RST_PC[1];
            half_valid_q  <= 1'b0;
            half_buf_q    <= 16'h0;
            inst_valid_q  <= 1'b0;
            inst_q        <= 32'h0;
            inst_pc_q     <= '0;
            inst_is_rvc_q <= 1'b0;
        end else begin
            pc_next_q     <= pc_next_d;
            off_q         <= off_d;
            half_valid_q  <= half_valid_d;
            half_buf_q    <= half_buf_d;
            inst_valid_q  <= inst_valid_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_is_rvc_q <= inst_is_rvc_d;
        end
    end

    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_is_rvc = inst_is_rvc_q;

endmodule

// File: doc/ifu_inst_align.md
Name: ifu_inst_align

Overview:
- Read-side consumer of the instruction-fetch FIFO. It pops 32-bit aligned fetch words and splits them into individual RV64IMAC instructions, either 16-bit RVC or 32-bit, including 32-bit instructions that straddle two fetch words.
- It tracks the PC of every instruction and presents one instruction per cycle to decode over a valid/ready handshake.
- Flush re-seeds it from a redirect PC.

Parameters:
- PC_LEN, 64, width of PC.
- RST_PC, 64'h0000_0000_8000_0000, PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; the block uses one clock, and reset is synchronous and active-high.
- flush  in  1  redirect; discard all buffered and output state.
- flush_pc  in  PC_LEN  redirect target; bit 0 ignored.
- fifo_empty  in  1  fetch FIFO empty.
- fifo_rdata  in  32  FIFO head word, combinational, valid when !fifo_empty.
- fifo_rready  out  1  pop the FIFO head this cycle.
- inst_valid  out  1  registered instruction available.
- inst_ready  in  1  decode accepts.
- inst  out  32  instruction; RVC is zero-extended in [31:16].
- inst_pc  out  PC_LEN  PC of inst.
- inst_is_rvc  out  1  inst is 16-bit.

Behaviour:
- State registers:
  - pc_next (PC_LEN): PC of the next halfword to consume.
  - off (1): which halfword of the FIFO head is next; 0 = [15:0], 1 = [31:16]. Always equals pc_next[1] except while half_valid.
  - half_valid (1) and half_buf (16): low half of a straddling 32-bit instruction.
  - Output register: inst_valid, inst, inst_pc, inst_is_rvc.
- Reset values: inst_valid=0, inst=0, inst_pc=0, inst_is_rvc=0, half_valid=0, half_buf=0, off=RST_PC[1], pc_next=RST_PC. fifo_rready is combinational and is 0 during reset.
- RVC test: a halfword h is RVC iff h[1:0] != 2'b11.
- adv = (!inst_valid | inst_ready) & !fifo_empty & !flush & !rst. When adv=0 nothing changes except the handshake clear below.
- Cases when adv=1:
  - A, half_valid=0, off=0, low = fifo_rdata[15:0]:
    - low RVC: issue {16'h0, low}, pc += 2, off <= 1, no pop.
    - else: issue fifo_rdata, pc += 4, pop, off stays 0.
  - B, half_valid=0, off=1, hi = fifo_rdata[31:16]:
    - hi RVC: issue {16'h0, hi}, pc += 2, pop, off <= 0.
    - else: half_buf <= hi, half_valid <= 1, pop, off <= 0, no issue. The bubble is acceptable.
  - C, half_valid=1: issue {fifo_rdata[15:0], half_buf}, inst_pc = pc_next, pc += 4, half_valid <= 0, off <= 1, no pop.
- fifo_rready = adv & (case A 32-bit | case B). It is never asserted when fifo_empty or flush is high.
- Issue loads the output register next edge: inst_valid <= 1, inst_pc <= pc_next, inst_is_rvc accordingly.
- Handshake clear: inst_valid & inst_ready with no new issue gives inst_valid <= 0. Output holds stable while inst_valid & !inst_ready.
- Latency: FIFO word present at cycle N produces inst_valid at N+1 (case C/A). A straddling instruction costs one extra cycle. Throughput is 1 instruction per cycle otherwise.
- Flush takes priority over everything except rst:
  - inst_valid <= 0, half_valid <= 0.
  - pc_next <= {flush_pc[PC_LEN-1:1], 1'b0}, off <= flush_pc[1].
  - No pop in the flush cycle. The FIFO is flushed by the same signal, so the head word after flush belongs to the new stream.
- Simultaneous inst_ready and issue: the accepted entry is replaced by the new one, with no bubble.
- pc_next wraps modulo 2^PC_LEN.
- Reset asserted mid-operation returns to the reset values on that edge. Any half_buf contents are discarded.

Decomposition:
- Shared package ifu_pkg: RVC_OPC_32 = 2'b11, PC_LEN, RST_PC, and the halfword-select encoding for off.
- No sub-module is required. Case selection and RVC detection are a single combinational block feeding registers.

Test Plan:
- Reset RST_PC = 0x8000_0000, FIFO holds 0x0041_0513 (32-bit addi) -> inst = 0x00410513, inst_pc = 0x80000000, inst_is_rvc = 0, one pop; next pc_next = 0x80000004.
- FIFO word 0x4501_4505 (two c.li) -> two issues on consecutive cycles:
  - 0x00004505 at pc 0x80000000.
  - 0x00004501 at 0x80000002, pop only on the second.
- Straddle case:
  - Setup: flush_pc = 0x80000002, words 0x0513_xxxx then 0x0000_0041.
  - After the first pop: half_valid = 1, no issue.
  - Next cycle: inst = 0x00410513, pc = 0x80000002.
  - Next pc_next = 0x80000006, off = 1.
- Backpressure: inst_ready = 0 for 5 cycles with FIFO non-empty -> inst/inst_pc stable, fifo_rready = 0 throughout. On release, back-to-back issue without a gap.
- Flush while half_valid = 1 and inst_valid = 1, flush_pc = 0x8000_1000 -> next cycle inst_valid = 0, half_valid = 0, pc_next = 0x80001000, no pop in the flush cycle.
- FIFO empty in case C (half_valid = 1) -> no issue, no pop, half_buf retained until a word arrives. Synchronous rst asserted then -> all reset values on the next edge.
